win3x3_tconv: RTL



---
 rtl/win3x3_tconv.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/win3x3_tconv.sv
// -----------------------------------------------------------------------------
// win3x3_tconv
// Ternary 3x3 window convolution stage fed by the three-row sign line buffer.
// Each column arrives as CHANNEL beats of three stacked 2-bit sign codes. Two
// per-channel delay buffers rebuild the horizontal window {x-2, x-1, x}. Each
// beat's 9 ternary taps are multiplied by per-channel ternary weights, summed,
// and the sums are accumulated over all channels into one signed output per
// pixel. Same-padding is applied at both row edges.
//
// Optional feature macro: WIN_RELU_EN (defined -> negative sums emitted as 0).
//
// Ports:
//   i_sclk   clock
//   i_rst    asynchronous active-high reset
//   i_vsync  frame start, synchronous clear of FSM/counters/accumulator/o_err
//   i_hsync  row start, one cycle before the first beat of the row
//   i_valid  column beat valid
//   i_tdata  {row r, row r-1, row r-2} 2-bit sign codes
//   i_wld    weight write strobe
//   i_waddr  weight channel address
//   i_wdata  9 ternary taps, tap k = 3*row + col at bits [2k+1:2k]
//   o_vsync  i_vsync delayed by one cycle
//   o_hsync  high with the first output pixel of each row
//   o_valid  one-cycle pulse per output pixel
//   o_tdata  signed window sum
//   o_err    sticky protocol error
// -----------------------------------------------------------------------------
module win3x3_tconv #(
    parameter int SIZE    = 28,
    parameter int CHANNEL = 128,
    parameter int ACC_W   = 12
) (
    input  logic                       i_sclk,
    input  logic                       i_rst,
    input  logic                       i_vsync,
    input  logic                       i_hsync,
    input  logic                       i_valid,
    input  logic [5:0]                 i_tdata,
    input  logic                       i_wld,
    input  logic [$clog2(CHANNEL)-1:0] i_waddr,
    input  logic [17:0]                i_wdata,
    output logic                       o_vsync,
    output logic                       o_hsync,
    output logic                       o_valid,
    output logic [ACC_W-1:0]           o_tdata,
    output logic                       o_err
);

    localparam int CH_W  = $clog2(CHANNEL);
    localparam int COL_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    // Ternary product: zero when either code is zero-valued, else sign XOR.
    function automatic logic signed [4:0] tap_prod(input logic [1:0] d, input logic [1:0] w);
        logic signed [4:0] p;
        if (!d[0] || !w[0]) begin
            p = 5'sd0;
        end else if (d[1] ^ w[1]) begin
            p = -5'sd1;
        end else begin
            p = 5'sd1;
        end
        return p;
    endfunction

    // Sum of the 9 tap products for one channel; columns c0 (left) .. c2 (right).
    function automatic logic signed [4:0] win_sum(input logic [5:0] c0, input logic [5:0] c1,
                                                  input logic [5:0] c2, input logic [17:0] wt);
        logic signed [4:0] s;
        logic [5:0]        tap_col;
        s = 5'sd0;
        for (int k = 0; k < 9; k++) begin
            case (k % 3)
                0:       tap_col = c0;
                1:       tap_col = c1;
                default: tap_col = c2;
            endcase
            s = s + tap_prod(tap_col[2*(k/3) +: 2], wt[2*k +: 2]);
        end
        return s;
    endfunction

    // Storage: weights, column x-1 buffer (B1) and column x-2 buffer (B2).
    logic [17:0] r_wmem [CHANNEL];
    logic [5:0]  r_b1   [CHANNEL];
    logic [5:0]  r_b2   [CHANNEL];

    state_t             r_state;
    logic [CH_W-1:0]    r_ch;
    logic [COL_W-1:0]   r_col;

    logic               r_s1_vld;
    logic signed [4:0]  r_s1_sum;
    logic               r_s1_first;
    logic               r_s1_last;
    logic               r_s1_out;
    logic               r_s1_hs;
    logic signed [ACC_W-1:0] r_acc;

    logic               w_beat;
    logic               w_step;
    logic               w_abort;
    logic               w_bad_valid;
    logic               w_ch_last;
    logic [5:0]         w_cur;
    logic [5:0]         w_mid;
    logic [5:0]         w_left;
    logic [17:0]        w_wt;
    logic signed [4:0]  w_sum;
    logic signed [ACC_W-1:0] w_s1_ext;
    logic signed [ACC_W-1:0] w_acc_next;
    logic [ACC_W-1:0]   w_out;

    // Decode beat/flush activity and assemble the edge-masked window for r_ch.
    always_comb begin
        w_beat      = i_valid && ((r_state == S_FIRST) || (r_state == S_RUN));
        w_step      = w_beat || (r_state == S_FLUSH);
        w_abort     = i_hsync && (r_state != S_IDLE);
        w_bad_valid = i_valid && ((r_state == S_IDLE) || (r_state == S_FLUSH));
        w_ch_last   = (r_ch == CH_W'(CHANNEL - 1));
        // Right pad: flush cycles present an all-zero current column.
        if (r_state == S_FLUSH) begin
            w_cur = 6'd0;
        end else begin
            w_cur = i_tdata;
        end
        if (r_state == S_FIRST) begin
            w_mid = 6'd0;
        end else begin
            w_mid = r_b1[r_ch];
        end
        // Left pad: the window centred on column 0 has no column -1.
        if ((r_state == S_FIRST) || ((r_state == S_RUN) && (r_col == COL_W'(1)))) begin
            w_left = 6'd0;
        end else begin
            w_left = r_b2[r_ch];
        end
        // Read sees the pre-write word when i_wld targets the same channel.
        w_wt  = r_wmem[r_ch];
        w_sum = win_sum(w_left, w_mid, w_cur, w_wt);
    end

    // Accumulator next value and optional rectification of the final sum.
    always_comb begin
        w_s1_ext = {{(ACC_W-5){r_s1_sum[4]}}, r_s1_sum};
        if (r_s1_first) begin
            w_acc_next = w_s1_ext;
        end else begin
            w_acc_next = r_acc + w_s1_ext;
        end
`ifdef WIN_RELU_EN
        if (w_acc_next[ACC_W-1]) begin
            w_out = {ACC_W{1'b0}};
        end else begin
            w_out = w_acc_next;
        end
`else
        w_out = w_acc_next;
`endif
    end

    // Weight RAM write port.
    always_ff @(posedge i_sclk) begin
        if (i_wld) begin
            r_wmem[i_waddr] <= i_wdata;
        end
    end

    // Column delay line: B2 takes the old B1 word, B1 takes the current column.
    always_ff @(posedge i_sclk) begin
        if (w_step) begin
            r_b2[r_ch] <= r_b1[r_ch];
            r_b1[r_ch] <= w_cur;
        end
    end

    // Row FSM with channel/column counters and sticky error flag.
    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ch    <= {CH_W{1'b0}};
            r_col   <= {COL_W{1'b0}};
            o_err   <= 1'b0;
        end else if (i_vsync) begin
            r_state <= S_IDLE;
            r_ch    <= {CH_W{1'b0}};
            r_col   <= {COL_W{1'b0}};
            o_err   <= 1'b0;
        end else begin
            o_err <= o_err | w_abort | w_bad_valid;
            if (i_hsync) begin
                // New row, or abort of the row in progress.
                r_state <= S_FIRST;
                r_ch    <= {CH_W{1'b0}};
                r_col   <= {COL_W{1'b0}};
            end else begin
                case (r_state)
                    S_FIRST: begin
                        if (w_beat) begin
                            if (w_ch_last) begin
                                r_ch    <= {CH_W{1'b0}};
                                r_col   <= COL_W'(1);
                                r_state <= S_RUN;
                            end else begin
                                r_ch <= r_ch + CH_W'(1);
                            end
                        end
                    end
                    S_RUN: begin
                        if (w_beat) begin
                            if (w_ch_last) begin
                                r_ch <= {CH_W{1'b0}};
                                if (r_col == COL_W'(SIZE - 1)) begin
                                    r_state <= S_FLUSH;
                                end else begin
                                    r_col <= r_col + COL_W'(1);
                                end
                            end else begin
                                r_ch <= r_ch + CH_W'(1);
                            end
                        end
                    end
                    S_FLUSH: begin
                        if (w_ch_last) begin
                            r_state <= S_IDLE;
                            r_ch    <= {CH_W{1'b0}};
                            r_col   <= {COL_W{1'b0}};
                        end else begin
                            r_ch <= r_ch + CH_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Two-stage datapath: register per-beat tap sum, then accumulate and emit.
    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_sum   <= 5'sd0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_out   <= 1'b0;
            r_s1_hs    <= 1'b0;
            r_acc      <= {ACC_W{1'b0}};
            o_valid    <= 1'b0;
            o_hsync    <= 1'b0;
            o_tdata    <= {ACC_W{1'b0}};
        end else if (i_vsync) begin
            r_s1_vld <= 1'b0;
            r_acc    <= {ACC_W{1'b0}};
            o_valid  <= 1'b0;
            o_hsync  <= 1'b0;
        end else begin
            // An aborted row must not leave a beat in flight.
            r_s1_vld   <= w_step && !w_abort;
            r_s1_sum   <= w_sum;
            r_s1_first <= (r_ch == {CH_W{1'b0}});
            r_s1_last  <= w_ch_last;
            r_s1_out   <= (r_state == S_RUN) || (r_state == S_FLUSH);
            r_s1_hs    <= (r_state == S_RUN) && (r_col == COL_W'(1));
            o_valid    <= 1'b0;
            o_hsync    <= 1'b0;
            if (r_s1_vld) begin
                r_acc <= w_acc_next;
                if (r_s1_last && r_s1_out) begin
                    o_valid <= 1'b1;
                    o_hsync <= r_s1_hs;
                    o_tdata <= w_out;
                end
            end
        end
    end

    // Frame-start pulse delayed to line up with the cleared pipeline.
    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            o_vsync <= 1'b0;
        end else begin
            o_vsync <= i_vsync;
        end
    end

endmodule
